// File: rtl/add_cfast_pipe.sv
//==================================================================
// add_cfast_pipe : pipelined parallel-prefix adder, {CO,S}=A+B+CI
//   The word is cut into `stages` slices; each slice adds with a
//   fast-carry-in prefix tree and hands its carry to the next stage
//   through a register. Valid/ready handshake with full backpressure.
//   Optional signed-overflow output OV: define ADDCFASTPIPE_OVF_EN.
// Revision: 1.0
//==================================================================
`default_nettype none

package lau_pkg;
  typedef enum logic [1:0] {
    SLOW = 2'd0,
    FAST = 2'd1
  } speed_t;
endpackage

module add_cfast_slice #(
  parameter int              n     = 4,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] s,
  output logic         co
);
  logic [n-1:0] g;
  logic [n-1:0] p;
  logic [n-1:0] gg;
  logic [n-1:0] pp;
  logic [n:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate prefix over bits [i:0], built without ci so
  // the carry-in only passes through the final AND-OR (fast carry-in).
  // FAST uses a Sklansky tree, SLOW a serial prefix chain.
  always_comb begin
    gg = g;
    pp = p;
    if (speed == lau_pkg::FAST) begin
      for (int l = 0; (1 << l) < n; l++) begin
        for (int i = n - 1; i > 0; i--) begin
          if (((i >> l) & 1) == 1) begin
            gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
            pp[i] = pp[i] & pp[((i >> l) << l) - 1];
          end
        end
      end
    end else begin
      for (int i = 1; i < n; i++) begin
        gg[i] = gg[i] | (pp[i] & gg[i - 1]);
        pp[i] = pp[i] & pp[i - 1];
      end
    end
  end

  assign c  = {gg | (pp & {n{ci}}), ci};
  assign s  = p ^ c[n-1:0];
  assign co = c[n];
endmodule

module add_cfast_pipe #(
  parameter int              width  = 32,
  parameter int              stages = 2,
  parameter lau_pkg::speed_t speed  = lau_pkg::FAST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  input  logic             VI,
  output logic             RO,
  output logic [width-1:0] S,
  output logic             CO,
  output logic             VO,
  input  logic             RI
`ifdef ADDCFASTPIPE_OVF_EN
  ,
  output logic             OV
`endif
);
  // Slice width; the last slice takes whatever is left over.
  localparam int W = (width + stages - 1) / stages;

  if (stages < 1 || stages > width || (stages - 1) * W >= width) begin : g_param_check
    $error("add_cfast_pipe: width/stages combination yields an empty slice");
  end

  logic [stages-1:0] vld;
  logic [stages-1:0] vin;
  logic [stages-1:0] acc;
  logic [stages-1:0] c_q;
  logic [stages-1:0] nxt_c;
  logic [width-1:0]  s_q   [stages];
  logic [width-1:0]  a_q   [stages];
  logic [width-1:0]  b_q   [stages];
  logic [width-1:0]  nxt_s [stages];
  logic [width-1:0]  nxt_a [stages];
  logic [width-1:0]  nxt_b [stages];
`ifdef ADDCFASTPIPE_OVF_EN
  logic nxt_ov;
  logic ov_q;
`endif

  for (genvar k = 0; k < stages; k++) begin : g_stage
    localparam int LO = k * W;
    localparam int HI = ((k + 1) * W > width) ? width : (k + 1) * W;
    localparam int N  = HI - LO;

    logic [width-1:0] a_src;
    logic [width-1:0] b_src;
    logic [width-1:0] s_src;
    logic [width-1:0] ns;
    logic             c_src;
    logic [N-1:0]     sl_s;
    logic             sl_c;

    if (k == 0) begin : g_head
      assign a_src  = A;
      assign b_src  = B;
      assign s_src  = '0;
      assign c_src  = CI;
      assign vin[k] = VI;
    end else begin : g_body
      assign a_src  = a_q[k-1];
      assign b_src  = b_q[k-1];
      assign s_src  = s_q[k-1];
      assign c_src  = c_q[k-1];
      assign vin[k] = vld[k-1];
    end

    // A stage can take new data unless it and every stage below it are full
    // and the output is stalled; written flat to avoid a ripple loop.
    assign acc[k] = RI | ~(&vld[stages-1:k]);

    add_cfast_slice #(
      .n     (N),
      .speed (speed)
    ) u_slice (
      .a  (a_src[LO +: N]),
      .b  (b_src[LO +: N]),
      .ci (c_src),
      .s  (sl_s),
      .co (sl_c)
    );

    // Splice this slice's sum into the partial sum travelling down the pipe.
    always_comb begin
      ns          = s_src;
      ns[LO +: N] = sl_s;
    end

    assign nxt_s[k] = ns;
    assign nxt_a[k] = a_src;
    assign nxt_b[k] = b_src;
    assign nxt_c[k] = sl_c;

`ifdef ADDCFASTPIPE_OVF_EN
    if (k == stages - 1) begin : g_ovf
      assign nxt_ov = (a_src[width-1] == b_src[width-1]) & (ns[width-1] != a_src[width-1]);
    end
`endif
  end

  // Stage registers: valid follows the accept condition, data loads only on a transfer.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < stages; k++) begin
      if (RST) begin
        vld[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end else begin
        if (acc[k]) begin
          vld[k] <= vin[k];
        end
        if (acc[k] & vin[k]) begin
          c_q[k] <= nxt_c[k];
          s_q[k] <= nxt_s[k];
          a_q[k] <= nxt_a[k];
          b_q[k] <= nxt_b[k];
        end
      end
    end
  end

`ifdef ADDCFASTPIPE_OVF_EN
  // Overflow flag shares the final stage's load/hold/reset behaviour.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ov_q <= 1'b0;
    end else if (acc[stages-1] & vin[stages-1]) begin
      ov_q <= nxt_ov;
    end
  end
  assign OV = ov_q;
`endif

  // Ready is forced high while in reset; the reset branch above still blocks the load.
  assign RO = acc[0] | RST;
  assign S  = s_q[stages-1];
  assign CO = c_q[stages-1];
  assign VO = vld[stages-1];
endmodule

`default_nettype wire

// File: tb/tb_add_cfast_pipe.sv
//==================================================================
// tb_add_cfast_pipe : bench for add_cfast_pipe
//   Main instance width=32/stages=4 with a scoreboard queue; a
//   width=10/stages=3 instance for uneven slices; with
//   ADDCFASTPIPE_OVF_EN a width=8 instance for the OV flag.
// Revision: 1.0
//==================================================================
`default_nettype none

module tb_add_cfast_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        vi;
  logic        ri;
  logic        ro;
  logic [31:0] s;
  logic        co;
  logic        vo;

  logic [9:0]  a10;
  logic [9:0]  b10;
  logic        ci10;
  logic        vi10;
  logic        ri10;
  logic        ro10;
  logic [9:0]  s10;
  logic        co10;
  logic        vo10;

`ifdef ADDCFASTPIPE_OVF_EN
  logic        ov32;
  logic        ov10;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        ci8;
  logic        vi8;
  logic        ri8;
  logic        ro8;
  logic [7:0]  s8;
  logic        co8;
  logic        vo8;
  logic        ov8;
`endif

  add_cfast_pipe #(.width(32), .stages(4)) u_dut (
    .CLK (clk), .RST (rst), .A (a), .B (b), .CI (ci), .VI (vi), .RO (ro),
    .S (s), .CO (co), .VO (vo), .RI (ri)
`ifdef ADDCFASTPIPE_OVF_EN
    , .OV (ov32)
`endif
  );

  add_cfast_pipe #(.width(10), .stages(3)) u_dut10 (
    .CLK (clk), .RST (rst), .A (a10), .B (b10), .CI (ci10), .VI (vi10), .RO (ro10),
    .S (s10), .CO (co10), .VO (vo10), .RI (ri10)
`ifdef ADDCFASTPIPE_OVF_EN
    , .OV (ov10)
`endif
  );

`ifdef ADDCFASTPIPE_OVF_EN
  add_cfast_pipe #(.width(8), .stages(2)) u_dut8 (
    .CLK (clk), .RST (rst), .A (a8), .B (b8), .CI (ci8), .VI (vi8), .RO (ro8),
    .S (s8), .CO (co8), .VO (vo8), .RI (ri8), .OV (ov8)
  );
`endif

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake bookkeeping for the main instance, called #1 after a negedge.
  task automatic sample();
    logic [32:0] e;
    if (rst) begin
      sb.delete();
    end else begin
      if (vo && ri) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_out observed VO=1 S=%0h expected no output", s);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sum", {co, s}, e);
        end
      end else if (vo && sb.size() > 0) begin
        check("hold", {co, s}, sb[0]);
      end
      if (vi && ro) begin
        sb.push_back({1'b0, a} + {1'b0, b} + {32'd0, ci});
      end
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    vi = 1'b0;
    ri = 1'b1;
    n  = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic run10(input logic [9:0] ta, input logic [9:0] tb, input logic tci,
                       input logic [9:0] es, input logic eco);
    int lat;
    a10  = ta;
    b10  = tb;
    ci10 = tci;
    vi10 = 1'b1;
    #1 check("w10_ro", ro10, 1);
    @(negedge clk);
    vi10 = 1'b0;
    lat  = 1;
    #1;
    while (!vo10 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("w10_latency", lat, 3);
    check("w10_s", s10, es);
    check("w10_co", co10, eco);
    @(negedge clk);
  endtask

`ifdef ADDCFASTPIPE_OVF_EN
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                      input logic [7:0] es, input logic eco, input logic eov);
    int lat;
    a8  = ta;
    b8  = tb;
    ci8 = tci;
    vi8 = 1'b1;
    @(negedge clk);
    vi8 = 1'b0;
    lat = 1;
    #1;
    while (!vo8 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("w8_latency", lat, 2);
    check("w8_s", s8, es);
    check("w8_co", co8, eco);
    check("w8_ov", ov8, eov);
    @(negedge clk);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic        took;
    logic [31:0] bp_a [6];
    logic [31:0] bp_b [6];

    rst  = 1'b1;
    a    = '0;
    b    = '0;
    ci   = 1'b0;
    vi   = 1'b0;
    ri   = 1'b1;
    a10  = '0;
    b10  = '0;
    ci10 = 1'b0;
    vi10 = 1'b0;
    ri10 = 1'b1;
`ifdef ADDCFASTPIPE_OVF_EN
    a8  = '0;
    b8  = '0;
    ci8 = 1'b0;
    vi8 = 1'b0;
    ri8 = 1'b1;
`endif

    // reset state
    @(negedge clk);
    #1 check("ro_in_reset", ro, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_vo", vo, 0);
    check("reset_s", s, 0);
    check("reset_co", co, 0);
    @(negedge clk);

    // carry ripples through all four slices; VO exactly 4 cycles later
    a  = 32'hFFFF_FFFF;
    b  = 32'h0;
    ci = 1'b1;
    vi = 1'b1;
    tick();
    vi = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      #1;
      check("latency_vo", vo, (cyc == 4) ? 1 : 0);
      sample();
      @(negedge clk);
    end
    check("latency_sb_empty", sb.size(), 0);

    // back-to-back random stream
    for (int i = 0; i < 100; i++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      vi = 1'b1;
      ri = 1'b1;
      #1;
      check("ro_stream", ro, 1);
      sample();
      @(negedge clk);
    end
    drain();

    // backpressure: RI low while 6 inputs are offered
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 32'h1000_0000 * i + 32'h0000_FFFF;
      bp_b[i] = 32'hF0F0_F0F0 ^ i;
    end
    ri  = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      a  = bp_a[idx];
      b  = bp_b[idx];
      ci = idx[0];
      vi = 1'b1;
      #1;
      took = vi && ro;
      sample();
      if (took) idx++;
      @(negedge clk);
    end
    check("bp_accepted", idx, 4);
    #1;
    check("bp_ro_low", ro, 0);
    check("bp_vo_high", vo, 1);
    sample();
    @(negedge clk);
    ri = 1'b1;
    for (int cyc = 0; cyc < 20 && idx < 6; cyc++) begin
      a  = bp_a[idx];
      b  = bp_b[idx];
      ci = idx[0];
      vi = 1'b1;
      #1;
      took = vi && ro;
      sample();
      if (took) idx++;
      @(negedge clk);
    end
    check("bp_all_accepted", idx, 6);
    drain();

    // reset with three transactions in flight; offer during reset too
    ri = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'b1;
      vi = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    check("ro_during_reset", ro, 1);
    sample();
    @(negedge clk);
    rst = 1'b0;
    vi  = 1'b0;
    #1;
    check("flush_vo", vo, 0);
    check("flush_s", s, 0);
    check("flush_co", co, 0);
    sample();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tick();
    end

    // uneven slices 4/4/2
    run10(10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1);
    run10(10'h155, 10'h0AA, 1'b1, 10'h200, 1'b0);
    run10(10'h2AA, 10'h155, 1'b1, 10'h000, 1'b1);

`ifdef ADDCFASTPIPE_OVF_EN
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    run8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
